// File: rtl/bounded_window_integrator_pkg.sv
// bounded_window_integrator_pkg: shared DSP helpers for the window integrator.
// rev 1.0
`default_nettype none

package bounded_window_integrator_pkg;

  // Output width that holds the exact sum of SIZE samples of WIDTH bits.
  function automatic int owidth(input int width, input int size);
    return width + $clog2(size + 1);
  endfunction

  // Interpret the low 'width' bits of value as two's complement.
  function automatic int sext(input int value, input int width);
    int masked;
    masked = value & ((1 << width) - 1);
    if (((masked >> (width - 1)) & 1) != 0)
      return masked - (1 << width);
    return masked;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bounded_window_integrator_sample_delay_line.sv
// sample_delay_line: DEPTH-stage shift register exposing the oldest sample.
// rev 1.0
`default_nettype none

module sample_delay_line
  import bounded_window_integrator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tap
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (shift_en) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tap = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/bounded_window_integrator.sv
// bounded_window_integrator: recursive moving-window sum over the last SIZE samples.
// rev 1.0
`default_nettype none

module bounded_window_integrator
  import bounded_window_integrator_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int SIZE   = 6,
  localparam int OWIDTH = owidth(WIDTH, SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [WIDTH-1:0]  i_tdata,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [OWIDTH-1:0] o_tdata,
  output logic              o_tvalid,
  input  logic              o_tready
);

  logic                     accept;
  logic [WIDTH-1:0]         oldest;
  logic signed [OWIDTH-1:0] x_ext;
  logic signed [OWIDTH-1:0] old_ext;
  logic signed [OWIDTH-1:0] acc;
  logic signed [OWIDTH-1:0] acc_next;

  assign i_tready = ~clear & (o_tready | ~o_tvalid);
  assign accept   = i_tvalid & i_tready;

  sample_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (SIZE)
  ) u_history (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .shift_en (accept),
    .din      (i_tdata),
    .tap      (oldest)
  );

  // The history tap is zero until SIZE samples arrive, giving partial sums at startup.
  assign x_ext    = OWIDTH'($signed(i_tdata));
  assign old_ext  = OWIDTH'($signed(oldest));
  assign acc_next = acc + x_ext - old_ext;

  // The accumulator doubles as the output data register: it only changes on accept.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc      <= '0;
      o_tvalid <= 1'b0;
    end else if (accept) begin
      acc      <= acc_next;
      o_tvalid <= 1'b1;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

  assign o_tdata = acc;

endmodule

`default_nettype wire

// File: tb/tb_bounded_window_integrator.sv
// tb_bounded_window_integrator: randomized and directed checks against a queue-based window-sum model.
// rev 1.0
`default_nettype none

module tb_bounded_window_integrator;
  import bounded_window_integrator_pkg::*;

  localparam int WIDTH  = 8;
  localparam int SIZE   = 6;
  localparam int OWIDTH = WIDTH + $clog2(SIZE + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic [WIDTH-1:0]  i_tdata;
  logic              i_tvalid;
  logic              i_tready;
  logic [OWIDTH-1:0] o_tdata;
  logic              o_tvalid;
  logic              o_tready;

  bounded_window_integrator #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .i_tdata  (i_tdata),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: every sample accepted since the last reset/clear, in order.
  int accepted[$];
  int m_data  = 0;
  bit m_valid = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int window_sum();
    int s = 0;
    int n = accepted.size();
    for (int k = (n > SIZE) ? n - SIZE : 0; k < n; k++) s += accepted[k];
    return s;
  endfunction

  function automatic int dut_sum();
    return sext(int'(o_tdata), OWIDTH);
  endfunction

  // One clock: drive inputs, check ready, advance model, check outputs.
  task automatic cyc(input bit v, input int d, input bit rdy, input bit clr, input bit rst);
    bit exp_rdy;
    i_tvalid = v;
    i_tdata  = d[WIDTH-1:0];
    o_tready = rdy;
    clear    = clr;
    reset    = rst;
    #1;
    exp_rdy = !clr && (rdy || !m_valid);
    check("i_tready", int'(i_tready), int'(exp_rdy));
    @(posedge clk);
    #1;
    if (rst || clr) begin
      accepted.delete();
      m_valid = 1'b0;
      m_data  = 0;
    end else if (v && exp_rdy) begin
      accepted.push_back(sext(d, WIDTH));
      m_data  = window_sum();
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    check("o_tvalid", int'(o_tvalid), int'(m_valid));
    check("o_tdata", dut_sum(), m_data);
  endtask

  int exp_alt[12]  = '{127, -1, 126, -2, 125, -3, -3, -3, -3, -3, -3, -3};
  int exp_hold[16] = '{127, 254, 381, 508, 635, 762, 762, 762,
                       507, 252, -3, -258, -513, -768, -768, -768};

  initial begin
    i_tvalid = 1'b0; i_tdata = '0; o_tready = 1'b1; clear = 1'b0; reset = 1'b1;

    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    check("reset_data", dut_sum(), 0);
    check("reset_valid", int'(o_tvalid), 0);

    for (int i = 0; i < 12; i++) begin
      cyc(1, (i % 2 == 0) ? 127 : -128, 1, 0, 0);
      check("alt_const", dut_sum(), exp_alt[i]);
    end

    cyc(0, 0, 1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, (i < 8) ? 127 : -128, 1, 0, 0);
      check("hold_const", dut_sum(), exp_hold[i]);
    end

    cyc(0, 0, 1, 1, 0);
    for (int i = 0; i < 256; i++) begin
      cyc(1, i, 1, 0, 0);
      if (i == 5)  check("ramp_5", dut_sum(), 15);
      if (i == 10) check("ramp_10", dut_sum(), 45);
    end

    // Backpressure with valid held high.
    for (int i = 0; i < 10; i++) begin
      int d = int'($urandom_range(0, 255));
      cyc(1, d, (i < 4 || i > 6), 0, 0);
    end
    cyc(0, 0, 1, 0, 0);

    // Clear pulse inside a constant stream, then restart.
    for (int i = 0; i < 8; i++) cyc(1, 127, 1, (i == 3), 0);
    // Mid-stream reset.
    cyc(1, 127, 1, 0, 1);
    check("midreset_data", dut_sum(), 0);
    check("midreset_valid", int'(o_tvalid), 0);

    // Valid on one cycle in three.
    for (int i = 0; i < 30; i++) cyc((i % 3 == 0), int'($urandom_range(0, 255)), 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
